sync_ram_bw: RTL and testbench
==============================

SYNC_RAM_BW -- requirements
Module: sync_ram_bw

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, address bits.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, word bits; must be a multiple of 8.
REQ-003 SHALL have parameter DEPTH, default 16, number of words; 1 <= DEPTH <= 2**ADDR_WIDTH.
REQ-004 SHALL have parameter OUT_REG, default 0; 0 gives read latency 1, 1 gives read latency 2 (extra output register).
REQ-005 SHALL have parameter INIT_ON_RESET, default 1; 1 enables the zero-clear engine after reset.
REQ-006 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-007 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-008 SHALL have port en, input, 1, access request this cycle.
REQ-009 SHALL have port we, input, 1, 1 = write and 0 = read, qualified by en.
REQ-010 SHALL have port be, input, DATA_WIDTH/8, byte-lane write enables; bit i covers din[8i+7:8i].
REQ-011 SHALL have port addr, input, ADDR_WIDTH, word address.
REQ-012 SHALL have port din, input, DATA_WIDTH, write data.
REQ-013 SHALL have port dout, output, DATA_WIDTH, registered read data.
REQ-014 SHALL have port rd_valid, output, 1, one-cycle pulse aligned with new dout read data.
REQ-015 SHALL have port init_busy, output, 1, clear engine active; requests ignored while high.

Function
REQ-016 SHALL run a two-state FSM, CLEAR and READY; CLEAR is entered on reset when INIT_ON_RESET=1, otherwise READY.
REQ-017 In CLEAR, SHALL write all-zero to word clr_ptr each cycle, with clr_ptr running 0..DEPTH-1 and incrementing by 1.
REQ-018 SHALL move from CLEAR to READY on the cycle after word DEPTH-1 is cleared, so init_busy is high for exactly DEPTH cycles after rst_n is first sampled high.
REQ-019 While init_busy=1, SHALL ignore en, we, be, addr and din, with no memory change and no rd_valid.
REQ-020 In READY, with en=1 and we=1, SHALL update only the byte lanes whose be bit is 1 at mem[addr]; other lanes keep their value; dout and rd_valid do not change.
REQ-021 In READY, with en=1, we=1 and be all zero, SHALL leave memory unchanged.
REQ-022 In READY, with en=1 and we=0, SHALL present mem[addr] on dout with rd_valid=1, both valid 1 cycle after the request edge (OUT_REG=0) or 2 cycles after (OUT_REG=1).
REQ-023 With OUT_REG=1, SHALL accept back-to-back reads every cycle, each producing its own rd_valid pulse in order.
REQ-024 dout SHALL hold its last read value when no read completes; rd_valid is 0 in such cycles.
REQ-025 A write followed by a read of the same address on the next cycle SHALL return the newly written data (no stale read).
REQ-026 For addr >= DEPTH, SHALL ignore writes; reads complete normally with dout = 0 and rd_valid = 1; the address is not wrapped.
REQ-027 With en=0, SHALL perform no access.

Reset
REQ-028 While rst_n=0, SHALL hold dout=0, rd_valid=0, clr_ptr=0, and init_busy = INIT_ON_RESET.
REQ-029 Reset SHALL flush any read in flight in the OUT_REG pipeline; no rd_valid for it after reset.
REQ-030 Reset asserted mid-CLEAR SHALL restart clearing from word 0 when rst_n returns high.
REQ-031 Memory array SHALL NOT be reset directly; with INIT_ON_RESET=0, contents survive reset.

Verification
REQ-032 Defaults; release rst_n -> init_busy high 16 cycles then low; reading addr 0..15 returns 0x00 with rd_valid each read.
REQ-033 DATA_WIDTH=32; write addr 3 din=0xAABBCCDD be=0b1111, then write din=0x11223344 be=0b0101 -> read addr 3 returns 0xAA22CC44.
REQ-034 OUT_REG=1; write 0xA5 at 1 and 0x5A at 2; read 1,2 on consecutive cycles -> dout=0xA5 then 0x5A, 2 and 3 cycles after the first read, rd_valid high both cycles.
REQ-035 DEPTH=12; write 0x77 to addr 13 -> read addr 13 returns 0x00 and read addr 1 is unchanged.
REQ-036 Write 0xA5 at addr 1 at cycle N and read addr 1 at cycle N+1 -> dout=0xA5 at N+2.
REQ-037 Pull rst_n low at clr_ptr=7 for 1 cycle -> init_busy stays high, clearing restarts at 0, and init_busy is high 16 cycles after release; with INIT_ON_RESET=0, data written before reset reads back unchanged.

Source files
------------

// File: rtl/sync_ram_bw.sv
// Single-port synchronous RAM with per-byte write enables, an optional
// extra read output register, and a zero-clear engine that runs after reset.
module sync_ram_bw #(
    parameter int unsigned ADDR_WIDTH    = 4,
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned DEPTH         = 16,
    parameter int unsigned OUT_REG       = 0,
    parameter int unsigned INIT_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   din,
    output logic [DATA_WIDTH-1:0]   dout,
    output logic                    rd_valid,
    output logic                    init_busy
);

    localparam int unsigned NUM_LANES = DATA_WIDTH / 8;
    localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam bit          FULL_MAP  = (64'(DEPTH) >= (64'(1) << ADDR_WIDTH));

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_e;

    localparam state_e RESET_STATE = (INIT_ON_RESET != 0) ? S_CLEAR : S_READY;

    // Control and output registers
    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clr_ptr_q, clr_ptr_d;
    logic                    init_busy_q, init_busy_d;
    logic [DATA_WIDTH-1:0]   dout_q, dout_d;
    logic                    rd_valid_q, rd_valid_d;

    // Storage array; intentionally has no reset
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    // Shared write port (clear engine or user write) and read request
    logic                    mem_we_c;
    logic [IDX_W-1:0]        mem_idx_c;
    logic [NUM_LANES-1:0]    mem_be_c;
    logic [DATA_WIDTH-1:0]   mem_wdata_c;
    logic                    rd_req_c;
    logic                    addr_in_range_c;
    logic [DATA_WIDTH-1:0]   rd_word_c;

    // Read-completion stage feeding the output register
    logic                    rd_done_c;
    logic [DATA_WIDTH-1:0]   rd_done_data_c;

    // Out-of-range addresses only exist when DEPTH leaves part of the map unused
    generate
        if (FULL_MAP) begin : g_full_map
            assign addr_in_range_c = 1'b1;
        end else begin : g_part_map
            assign addr_in_range_c = (32'(addr) < DEPTH);
        end
    endgenerate

    // Unmapped addresses read as zero rather than aliasing onto real words
    assign rd_word_c = addr_in_range_c ? mem[IDX_W'(addr)] : '0;

    // Next-state, clear pointer and write-port steering
    always_comb begin
        state_d     = state_q;
        clr_ptr_d   = clr_ptr_q;
        mem_we_c    = 1'b0;
        mem_idx_c   = IDX_W'(clr_ptr_q);
        mem_be_c    = '0;
        mem_wdata_c = '0;
        rd_req_c    = 1'b0;

        // Nothing touches the array while reset is asserted
        if (rst_n) begin
            case (state_q)
                S_CLEAR: begin
                    mem_we_c  = 1'b1;
                    mem_be_c  = '1;
                    mem_idx_c = IDX_W'(clr_ptr_q);
                    if (clr_ptr_q == ADDR_WIDTH'(DEPTH - 1)) begin
                        state_d   = S_READY;
                        clr_ptr_d = '0;
                    end else begin
                        clr_ptr_d = clr_ptr_q + ADDR_WIDTH'(1);
                    end
                end
                S_READY: begin
                    if (en) begin
                        if (we) begin
                            mem_we_c    = addr_in_range_c;
                            mem_be_c    = be;
                            mem_idx_c   = IDX_W'(addr);
                            mem_wdata_c = din;
                        end else begin
                            rd_req_c = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = S_READY;
                end
            endcase
        end
    end

    // Busy flag follows the state the FSM is about to enter
    always_comb begin
        init_busy_d = (state_d == S_CLEAR);
    end

    // Optional pipeline stage between the array read and the output register
    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic                  rd_pend_q, rd_pend_d;
            logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

            // Capture the addressed word alongside its valid bit
            always_comb begin
                rd_pend_d = rd_req_c;
                rd_data_d = rd_req_c ? rd_word_c : rd_data_q;
            end

            // Stage register; reset drops any read in flight
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    rd_pend_q <= 1'b0;
                    rd_data_q <= '0;
                end else begin
                    rd_pend_q <= rd_pend_d;
                    rd_data_q <= rd_data_d;
                end
            end

            assign rd_done_c      = rd_pend_q;
            assign rd_done_data_c = rd_data_q;
        end else begin : g_no_out_reg
            assign rd_done_c      = rd_req_c;
            assign rd_done_data_c = rd_word_c;
        end
    endgenerate

    // Output register holds the last read word until another read completes
    always_comb begin
        rd_valid_d = rd_done_c;
        dout_d     = rd_done_c ? rd_done_data_c : dout_q;
    end

    // Control and output flops with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= RESET_STATE;
            clr_ptr_q   <= '0;
            init_busy_q <= (INIT_ON_RESET != 0);
            dout_q      <= '0;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_ptr_q   <= clr_ptr_d;
            init_busy_q <= init_busy_d;
            dout_q      <= dout_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    // Byte-lane masked array write
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (mem_be_c[i]) begin
                    mem[mem_idx_c][8*i +: 8] <= mem_wdata_c[8*i +: 8];
                end
            end
        end
    end

    assign dout      = dout_q;
    assign rd_valid  = rd_valid_q;
    assign init_busy = init_busy_q;

endmodule

// File: tb/tb_sync_ram_bw.sv
// Bench for sync_ram_bw: instance A uses the default parameters, instance B is
// 32-bit wide, 12 words deep, with the output register and no clear engine.
module tb_sync_ram_bw;

    logic        clk;
    logic        rst_a_n, rst_b_n;
    logic        en_a, en_b;
    logic        we;
    logic [3:0]  be;
    logic [3:0]  addr;
    logic [31:0] din;

    logic [7:0]  dout_a;
    logic        rd_valid_a, init_busy_a;
    logic [31:0] dout_b;
    logic        rd_valid_b, init_busy_b;

    int          checks;
    int          failures;
    bit          mon_on;

    logic [7:0]  q_a[$];
    logic [31:0] q_b[$];
    logic [7:0]  exp_a;
    logic [31:0] exp_b;

    sync_ram_bw u_a (
        .clk       (clk),
        .rst_n     (rst_a_n),
        .en        (en_a),
        .we        (we),
        .be        (be[0:0]),
        .addr      (addr),
        .din       (din[7:0]),
        .dout      (dout_a),
        .rd_valid  (rd_valid_a),
        .init_busy (init_busy_a)
    );

    sync_ram_bw #(
        .ADDR_WIDTH    (4),
        .DATA_WIDTH    (32),
        .DEPTH         (12),
        .OUT_REG       (1),
        .INIT_ON_RESET (0)
    ) u_b (
        .clk       (clk),
        .rst_n     (rst_b_n),
        .en        (en_b),
        .we        (we),
        .be        (be),
        .addr      (addr),
        .din       (din),
        .dout      (dout_b),
        .rd_valid  (rd_valid_b),
        .init_busy (init_busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every rd_valid pulse must match the oldest expected word
    always @(negedge clk) begin
        if (mon_on) begin
            if (rd_valid_a === 1'b1) begin
                checks++;
                if (q_a.size() == 0) begin
                    failures++;
                    $display("FAIL rd_a_unexpected: got dout=%0h with no read pending", dout_a);
                end else begin
                    exp_a = q_a.pop_front();
                    if (dout_a !== exp_a) begin
                        failures++;
                        $display("FAIL rd_a_data: got %0h expected %0h", dout_a, exp_a);
                    end
                end
            end else if (rd_valid_a !== 1'b0) begin
                checks++;
                failures++;
                $display("FAIL rd_a_valid_x: got %b expected 0/1", rd_valid_a);
            end
            if (rd_valid_b === 1'b1) begin
                checks++;
                if (q_b.size() == 0) begin
                    failures++;
                    $display("FAIL rd_b_unexpected: got dout=%0h with no read pending", dout_b);
                end else begin
                    exp_b = q_b.pop_front();
                    if (dout_b !== exp_b) begin
                        failures++;
                        $display("FAIL rd_b_data: got %0h expected %0h", dout_b, exp_b);
                    end
                end
            end else if (rd_valid_b !== 1'b0) begin
                checks++;
                failures++;
                $display("FAIL rd_b_valid_x: got %b expected 0/1", rd_valid_b);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr_a(input logic [3:0] a, input logic [7:0] d, input logic b);
        en_a = 1'b1; we = 1'b1; addr = a; din = {24'h0, d}; be = {3'b000, b};
        @(negedge clk);
        en_a = 1'b0; we = 1'b0;
    endtask

    task automatic rd_a(input logic [3:0] a, input logic [7:0] e);
        en_a = 1'b1; we = 1'b0; addr = a;
        q_a.push_back(e);
        @(negedge clk);
        en_a = 1'b0;
    endtask

    task automatic wr_b(input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
        en_b = 1'b1; we = 1'b1; addr = a; din = d; be = b;
        @(negedge clk);
        en_b = 1'b0; we = 1'b0;
    endtask

    task automatic rd_b(input logic [3:0] a, input logic [31:0] e);
        en_b = 1'b1; we = 1'b0; addr = a;
        q_b.push_back(e);
        @(negedge clk);
        en_b = 1'b0;
    endtask

    task automatic drained(input string name);
        idle(4);
        checks++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            failures++;
            $display("FAIL %s_drain: got pending a=%0d b=%0d expected 0 0", name, q_a.size(), q_b.size());
        end
    endtask

    task automatic test_reset();
        idle(3);
        checks++;
        if (dout_a !== 8'h00 || rd_valid_a !== 1'b0 || init_busy_a !== 1'b1) begin
            failures++;
            $display("FAIL reset_a: got dout=%0h v=%b busy=%b expected 0 0 1", dout_a, rd_valid_a, init_busy_a);
        end
        checks++;
        if (dout_b !== 32'h0 || rd_valid_b !== 1'b0 || init_busy_b !== 1'b0) begin
            failures++;
            $display("FAIL reset_b: got dout=%0h v=%b busy=%b expected 0 0 0", dout_b, rd_valid_b, init_busy_b);
        end
        mon_on = 1'b1;
    endtask

    task automatic test_clear();
        int cnt;
        cnt = 0;
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        // Writes and a read issued while busy must all be dropped
        for (int i = 0; i < 40; i++) begin
            if (init_busy_a !== 1'b1) break;
            cnt++;
            en_a = (i >= 7 && i <= 10) || (i == 12);
            we   = (i != 12);
            addr = (i == 12) ? 4'd3 : 4'd2;
            din  = 32'hFF;
            be   = 4'hF;
            @(negedge clk);
        end
        en_a = 1'b0; we = 1'b0;
        checks++;
        if (cnt != 16) begin
            failures++;
            $display("FAIL clear_busy_len: got %0d expected 16", cnt);
        end
        for (int a = 0; a < 16; a++) rd_a(4'(a), 8'h00);
        drained("clear");
    endtask

    task automatic test_byte_lanes();
        wr_b(4'd0, 32'h01010101, 4'hF);
        wr_b(4'd3, 32'hAABBCCDD, 4'hF);
        wr_b(4'd3, 32'h11223344, 4'h5);
        rd_b(4'd3, 32'hAA22CC44);
        wr_b(4'd3, 32'hFFFFFFFF, 4'h0);
        rd_b(4'd3, 32'hAA22CC44);
        wr_b(4'd5, 32'h00000000, 4'hF);
        wr_b(4'd5, 32'h12345678, 4'h8);
        rd_b(4'd5, 32'h12000000);
        wr_a(4'd4, 8'h3C, 1'b1);
        wr_a(4'd4, 8'hFF, 1'b0);
        rd_a(4'd4, 8'h3C);
        drained("lanes");
    endtask

    task automatic test_back_to_back();
        wr_b(4'd1, 32'h000000A5, 4'hF);
        wr_b(4'd2, 32'h0000005A, 4'hF);
        rd_b(4'd1, 32'h000000A5);
        rd_b(4'd2, 32'h0000005A);
        checks++;
        if (rd_valid_b !== 1'b1 || dout_b !== 32'hA5) begin
            failures++;
            $display("FAIL b2b_first: got v=%b dout=%0h expected 1 a5", rd_valid_b, dout_b);
        end
        @(negedge clk);
        checks++;
        if (rd_valid_b !== 1'b1 || dout_b !== 32'h5A) begin
            failures++;
            $display("FAIL b2b_second: got v=%b dout=%0h expected 1 5a", rd_valid_b, dout_b);
        end
        @(negedge clk);
        checks++;
        if (rd_valid_b !== 1'b0 || dout_b !== 32'h5A) begin
            failures++;
            $display("FAIL b2b_hold: got v=%b dout=%0h expected 0 5a", rd_valid_b, dout_b);
        end
        drained("b2b");
    endtask

    task automatic test_out_of_range();
        wr_b(4'd13, 32'h00000077, 4'hF);
        rd_b(4'd13, 32'h0);
        rd_b(4'd1, 32'h000000A5);
        wr_b(4'd11, 32'hCAFEF00D, 4'hF);
        wr_b(4'd12, 32'hDEADBEEF, 4'hF);
        rd_b(4'd11, 32'hCAFEF00D);
        rd_b(4'd12, 32'h0);
        rd_b(4'd0, 32'h01010101);
        rd_b(4'd15, 32'h0);
        drained("oor");
    endtask

    task automatic test_write_then_read();
        wr_a(4'd1, 8'hA5, 1'b1);
        rd_a(4'd1, 8'hA5);
        checks++;
        if (rd_valid_a !== 1'b1 || dout_a !== 8'hA5) begin
            failures++;
            $display("FAIL wr_rd_latency: got v=%b dout=%0h expected 1 a5", rd_valid_a, dout_a);
        end
        idle(2);
        checks++;
        if (rd_valid_a !== 1'b0 || dout_a !== 8'hA5) begin
            failures++;
            $display("FAIL dout_hold: got v=%b dout=%0h expected 0 a5", rd_valid_a, dout_a);
        end
        // A write presented with en low must not land
        en_a = 1'b0; we = 1'b1; addr = 4'd4; din = 32'h0; be = 4'h1;
        @(negedge clk);
        we = 1'b0;
        rd_a(4'd4, 8'h3C);
        drained("wr_rd");
    endtask

    task automatic test_reset_mid_clear();
        int  cnt;
        bit  busy_ok;
        busy_ok = 1'b1;
        for (int a = 0; a < 16; a++) wr_a(4'(a), 8'hEE, 1'b1);
        // Read in flight on B when reset hits must never complete
        en_b = 1'b1; we = 1'b0; addr = 4'd3;
        @(negedge clk);
        en_b = 1'b0;
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        @(negedge clk);
        checks++;
        if (dout_a !== 8'h00 || init_busy_a !== 1'b1 || dout_b !== 32'h0 || rd_valid_b !== 1'b0) begin
            failures++;
            $display("FAIL reset_again: got a=%0h busy=%b b=%0h v=%b expected 0 1 0 0",
                     dout_a, init_busy_a, dout_b, rd_valid_b);
        end
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (init_busy_a !== 1'b1) busy_ok = 1'b0;
            if (i == 7) rst_a_n = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (init_busy_a !== 1'b1 || !busy_ok) begin
            failures++;
            $display("FAIL mid_clear_busy: got busy=%b ok=%b expected 1 1", init_busy_a, busy_ok);
        end
        rst_a_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (init_busy_a !== 1'b1) break;
            cnt++;
            @(negedge clk);
        end
        checks++;
        if (cnt != 16) begin
            failures++;
            $display("FAIL restart_busy_len: got %0d expected 16", cnt);
        end
        for (int a = 0; a < 16; a++) rd_a(4'(a), 8'h00);
        rd_b(4'd3, 32'hAA22CC44);
        rd_b(4'd1, 32'h000000A5);
        rd_b(4'd11, 32'hCAFEF00D);
        drained("mid_clear");
    endtask

    initial begin
        checks = 0; failures = 0; mon_on = 1'b0;
        rst_a_n = 1'b0; rst_b_n = 1'b0;
        en_a = 1'b0; en_b = 1'b0; we = 1'b0; be = 4'h0; addr = 4'h0; din = 32'h0;
        test_reset();
        test_clear();
        test_byte_lanes();
        test_back_to_back();
        test_out_of_range();
        test_write_then_read();
        test_reset_mid_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
